mult_div_unit: RTL
==================

# mult_div_unit

- Execute-stage multiply/divide unit of the pipelined MIPS core.
- Sits beside the ALU. It takes the same forwarded operands and feeds the E-stage result select through mfhi/mflo.
- Owns the HI/LO registers and models multi-cycle mult/multu/div/divu latency with a Busy flag, which the hazard unit uses to stall later HI/LO instructions.
- Honours the exception/interrupt flush request so that a squashed E-stage instruction never modifies HI/LO.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy duration for mult/multu (legal range 1-15).
- DIV_CYCLES, 10, Busy duration for div/divu (legal range 1-15).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- SrcA  input  32  forwarded rs operand.
- SrcB  input  32  forwarded rt operand.
- MDUOp  input  4  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; all other codes behave as none.
- Start  input  1  E-stage instruction is mult/multu/div/divu; qualifies MDUOp 1-4.
- Req  input  1  exception/interrupt flush this cycle; suppresses every write by the current E-stage instruction.
- Busy  output  1  computation in progress.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.
- Result  output  32  combinational; HI when MDUOp=7, LO when MDUOp=8, else 0.

## Operation
State:
- HI, LO, PendHI, PendLO: 32-bit registers.
- Cnt: 4-bit counter.
- Busy = (Cnt != 0).

Launch:
- A launch occurs on an edge where Start=1, Req=0, Busy=0 and MDUOp is 1-4.
- At that edge, Cnt loads MULT_CYCLES or DIV_CYCLES and the result is computed into PendHI/PendLO.
- mult: signed 64-bit product; PendHI = [63:32], PendLO = [31:0].
- multu: unsigned 64-bit product.
- div: signed; PendLO = quotient truncated toward zero, PendHI = remainder with the sign of the dividend.
- Signed division 0x80000000 / 0xFFFFFFFF gives PendLO=0x80000000, PendHI=0x00000000.
- divu: unsigned quotient and remainder.
- Divide by zero (SrcB=0): PendHI/PendLO are loaded with the current HI/LO, so the commit leaves HI/LO unchanged. Busy still lasts DIV_CYCLES.

Countdown and commit:
- While Busy, Cnt decrements by 1 per edge.
- On the edge where Cnt goes from 1 to 0, HI<=PendHI and LO<=PendLO.
- A committing operation is older than the E-stage instruction, so Req does not cancel it.

Moves:
- mthi/mtlo write HI/LO with SrcA at the edge, only when Req=0 and Busy=0.
- mthi/mtlo while Busy are ignored. The hazard unit must stall them, so this case is a protocol violation but must not corrupt state.

Protocol violations:
- Start while Busy is ignored: no relaunch, Cnt and Pend registers are not disturbed.

Result:
- Reads the committed HI/LO only, never Pend.
- While Busy it returns the old value; the hazard unit stalls the read.

Reset:
- HI, LO, PendHI, PendLO, Cnt all go to 0, so Busy=0.
- Reset mid-operation aborts it; no later commit occurs.
- Reset has priority over launch, move and commit.

## Timing
- Launch at edge ending cycle T gives Busy=1 in cycles T+1 through T+N, where N is MULT_CYCLES or DIV_CYCLES.
- HI/LO take the new values in cycle T+N+1; Busy=0 in that cycle.
- The earliest next launch is at the edge ending cycle T+N+1.
- Busy is not asserted in the launch cycle T itself. The hazard unit must treat Start|Busy as busy.
- mthi/mtlo take 1 cycle: the value is visible on HI/LO and Result in the next cycle.
- Result has zero latency and is combinational from MDUOp and HI/LO.
- Req=1 together with Start or a move: no state change. Busy stays at its prior value, and any ongoing countdown and commit proceed.
- Commit edge coinciding with a move instruction: impossible, because moves are rejected while Busy.
- Reset values: Busy=0, HI=0, LO=0, Result=0 unless MDUOp is 7/8 (then 0 from the reset HI/LO).

## Test plan
1. mult with SrcA=0xFFFFFFFF, SrcB=2, Start at T:
   - Busy=1 in T+1..T+5.
   - In T+6: HI=0xFFFFFFFF, LO=0xFFFFFFFE, Busy=0.
2. multu with the same operands:
   - In T+6: HI=0x00000001, LO=0xFFFFFFFE.
3. div 0xFFFFFFF9 / 2 (i.e. -7/2):
   - In T+11: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
   - Then divu 7/0 from HI=LO=0x11: Busy high for 10 cycles, HI/LO stay 0x11.
4. div 0x80000000 / 0xFFFFFFFF:
   - LO=0x80000000, HI=0x00000000 after 10 Busy cycles.
5. Req and move handling:
   - Start=1 with MDUOp=1 and Req=1: Busy stays 0, HI/LO unchanged.
   - mthi SrcA=0x1234 with Req=1: HI unchanged.
   - mthi SrcA=0x1234 with Req=0: HI=0x1234 next cycle; MDUOp=7 then drives Result=0x1234.
   - mtlo issued during Busy: LO unchanged.
6. Reset mid-operation:
   - Launch mult with HI/LO nonzero, assert reset at T+3.
   - Expected: Busy=0 and HI=LO=0 from T+4, no commit at T+6.
   - A new launch right after reset completes normally.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Operand, control and result bundle between the E stage and the multiply/divide unit.
interface mult_div_unit_if;
   logic [31:0] SrcA;
   logic [31:0] SrcB;
   logic [3:0]  MDUOp;
   logic        Start;
   logic        Req;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] Result;

   modport master (
      output SrcA, SrcB, MDUOp, Start, Req,
      input  Busy, HI, LO, Result
   );

   modport slave (
      input  SrcA, SrcB, MDUOp, Start, Req,
      output Busy, HI, LO, Result
   );
endinterface

// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: owns HI/LO, computes at launch and commits after a
// fixed countdown so the hazard unit sees a realistic multi-cycle Busy window.
module mult_div_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input logic             clk,
   input logic             reset,
   mult_div_unit_if.slave  bus
);

   localparam logic [3:0] OP_MULT  = 4'd1;
   localparam logic [3:0] OP_MULTU = 4'd2;
   localparam logic [3:0] OP_DIV   = 4'd3;
   localparam logic [3:0] OP_DIVU  = 4'd4;
   localparam logic [3:0] OP_MTHI  = 4'd5;
   localparam logic [3:0] OP_MTLO  = 4'd6;
   localparam logic [3:0] OP_MFHI  = 4'd7;
   localparam logic [3:0] OP_MFLO  = 4'd8;

   logic [31:0] hi_q, lo_q, pend_hi_q, pend_lo_q;
   logic [3:0]  cnt_q;
   logic        busy;
   logic        launch;
   logic        is_signed;
   logic        is_mul;
   logic [63:0] mul_a, mul_b, product;
   logic [31:0] dvd_mag, dvs_mag, quo_mag, rem_mag;
   logic [31:0] quo, rem;
   logic [31:0] next_hi, next_lo;

   assign busy   = (cnt_q != 4'd0);
   assign launch = bus.Start && !bus.Req && !busy &&
                   (bus.MDUOp >= OP_MULT) && (bus.MDUOp <= OP_DIVU);

   assign is_signed = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_DIV);
   assign is_mul    = (bus.MDUOp == OP_MULT) || (bus.MDUOp == OP_MULTU);

   // Low 64 bits of a 64x64 product of sign/zero-extended operands give both flavours.
   assign mul_a   = {{32{is_signed & bus.SrcA[31]}}, bus.SrcA};
   assign mul_b   = {{32{is_signed & bus.SrcB[31]}}, bus.SrcB};
   assign product = mul_a * mul_b;

   // Signed divide on magnitudes; 0x80000000 magnitude still fits in 32 unsigned bits,
   // which makes the 0x80000000 / -1 overflow case wrap to 0x80000000 naturally.
   assign dvd_mag = (is_signed && bus.SrcA[31]) ? -bus.SrcA : bus.SrcA;
   assign dvs_mag = (bus.SrcB == 32'd0) ? 32'd1 :
                    ((is_signed && bus.SrcB[31]) ? -bus.SrcB : bus.SrcB);
   assign quo_mag = dvd_mag / dvs_mag;
   assign rem_mag = dvd_mag % dvs_mag;
   assign quo     = (is_signed && (bus.SrcA[31] ^ bus.SrcB[31])) ? -quo_mag : quo_mag;
   assign rem     = (is_signed && bus.SrcA[31]) ? -rem_mag : rem_mag;

   always_comb begin
      next_hi = hi_q;
      next_lo = lo_q;
      if (is_mul) begin
         next_hi = product[63:32];
         next_lo = product[31:0];
      end else if (bus.SrcB != 32'd0) begin
         next_hi = rem;
         next_lo = quo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         pend_hi_q <= 32'd0;
         pend_lo_q <= 32'd0;
         cnt_q     <= 4'd0;
      end else begin
         if (launch) begin
            cnt_q     <= is_mul ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            pend_hi_q <= next_hi;
            pend_lo_q <= next_lo;
         end else if (busy) begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               hi_q <= pend_hi_q;
               lo_q <= pend_lo_q;
            end
         end
         if (!busy && !bus.Req) begin
            if (bus.MDUOp == OP_MTHI) hi_q <= bus.SrcA;
            if (bus.MDUOp == OP_MTLO) lo_q <= bus.SrcA;
         end
      end
   end

   always_comb begin
      unique case (bus.MDUOp)
         OP_MFHI: bus.Result = hi_q;
         OP_MFLO: bus.Result = lo_q;
         default: bus.Result = 32'd0;
      endcase
   end

   assign bus.Busy = busy;
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule
